// File: rtl/aes_round_key_scheduler_if.sv
// Round-key request/delivery bundle between the cipher round controller
// and aes_round_key_scheduler.
//   rk_req    requester -> scheduler  round-key request
//   rk_round  requester -> scheduler  requested round index
//   rk_ready  scheduler -> requester  scheduler can accept rk_req
//   rk_valid  scheduler -> requester  one-cycle pulse, rk_data holds the key
//   rk_data   scheduler -> requester  128-bit round key (word 4r in [127:96])
//   rk_err    scheduler -> requester  one-cycle pulse, round out of range
// Modports: master = round controller, slave = scheduler.
interface aes_round_key_scheduler_if;
    logic         rk_req;
    logic [3:0]   rk_round;
    logic         rk_ready;
    logic         rk_valid;
    logic [127:0] rk_data;
    logic         rk_err;

    modport master (
        output rk_req, rk_round,
        input  rk_ready, rk_valid, rk_data, rk_err
    );

    modport slave (
        input  rk_req, rk_round,
        output rk_ready, rk_valid, rk_data, rk_err
    );
endinterface

// File: rtl/aes_round_key_scheduler.sv
// aes_round_key_scheduler
// Arbitrates the 64x32 round-key memory between the key-expansion
// controller (owner while keydone=0) and this scheduler (owner while
// keydone=1). On a request it reads the four words of one round key and
// delivers them as a single 128-bit word.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   length            key length (00/01: Nr=10, 10: Nr=12, 11: Nr=14)
//   keydone           expansion complete, memory owned by the scheduler
//   ksa_address       key-expansion memory address
//   ksa_mem_r_wbar    key-expansion read/write_bar
//   mem_address       key memory address
//   mem_r_wbar        key memory read/write_bar (1 = read)
//   mem_rdata         key memory read data, MEM_LAT cycles after address
//   rk                round-key handshake (aes_round_key_scheduler_if.slave)
// Parameter MEM_LAT: memory read latency, 1 or 2.
// Optional feature macro RK_CACHE_EN: one-entry tag of the last delivered
// round; a matching request is answered without touching the memory.
module aes_round_key_scheduler #(
    parameter int MEM_LAT = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [1:0]                      length,
    input  logic                            keydone,
    input  logic [5:0]                      ksa_address,
    input  logic                            ksa_mem_r_wbar,
    output logic [5:0]                      mem_address,
    output logic                            mem_r_wbar,
    input  logic [31:0]                     mem_rdata,
    aes_round_key_scheduler_if.slave        rk
);
    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, DONE} state_t;

    state_t       state, state_nxt;
    logic [3:0]   round_q;
    logic [1:0]   cnt_q;
    logic [5:0]   sched_addr_q;
    logic [3:0]   nr;
    logic         round_bad;
    logic         rk_ready_int;
    logic         accept;
    logic         cache_hit;
    logic         rk_valid_q;
    logic [127:0] rk_data_q;

    logic         issue_vld_p0;
    logic [1:0]   issue_slot_p0;
    logic         rd_vld_p1, rd_vld_p2;
    logic [1:0]   rd_slot_p1, rd_slot_p2;
    logic         cap_vld;
    logic [1:0]   cap_slot;
    logic         last_cap;
    logic [31:0]  key_buf_q [0:3];

    always_comb begin
        nr = 4'd10;
        case (length)
            2'b10:   nr = 4'd12;
            2'b11:   nr = 4'd14;
            default: nr = 4'd10;
        endcase
    end

    assign round_bad = (round_q > nr);
    // rst is folded in so rk_ready reads 0 while reset is held
    assign rk_ready_int = rst & keydone & (state == IDLE);
    assign accept = rk.rk_req & rk_ready_int;

`ifdef RK_CACHE_EN
    logic       tag_vld_q;
    logic [3:0] tag_round_q;
    logic [1:0] length_q;

    // Tag drops on key reload and on the cycle a length change is seen;
    // the length_q compare also blocks a hit in that very cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_vld_q   <= 1'b0;
            tag_round_q <= 4'd0;
            length_q    <= 2'b00;
        end else begin
            length_q <= length;
            if (!keydone || (length != length_q)) begin
                tag_vld_q <= 1'b0;
            end else if (state == DONE) begin
                tag_vld_q   <= 1'b1;
                tag_round_q <= round_q;
            end
        end
    end

    assign cache_hit = tag_vld_q & (tag_round_q == rk.rk_round) & (length == length_q);
`else
    assign cache_hit = 1'b0;
`endif

    // p0: address cycle; slot index travels with the read
    assign issue_vld_p0  = (state == ISSUE);
    assign issue_slot_p0 = cnt_q;

    // p1/p2: read returns; data is valid in the stage matching MEM_LAT
    assign cap_vld  = (MEM_LAT == 1) ? rd_vld_p1  : rd_vld_p2;
    assign cap_slot = (MEM_LAT == 1) ? rd_slot_p1 : rd_slot_p2;
    assign last_cap = cap_vld & (cap_slot == 2'd3);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !cache_hit) state_nxt = CHECK;
            CHECK:   state_nxt = round_bad ? IDLE : ISSUE;
            ISSUE:   if (cnt_q == 2'd3) state_nxt = WAIT;
            WAIT:    if (last_cap) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Key reload takes the memory back immediately
        if (!keydone) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            round_q      <= 4'd0;
            cnt_q        <= 2'd0;
            sched_addr_q <= 6'd0;
            rd_vld_p1    <= 1'b0;
            rd_vld_p2    <= 1'b0;
            rk_valid_q   <= 1'b0;
            rk_data_q    <= '0;
        end else begin
            state      <= state_nxt;
            rd_vld_p1  <= keydone & issue_vld_p0;
            rd_vld_p2  <= keydone & rd_vld_p1;
            rk_valid_q <= keydone & ((state == DONE) | (accept & cache_hit));
            if (accept) round_q <= rk.rk_round;
            if (keydone && (state == CHECK) && !round_bad) begin
                cnt_q        <= 2'd0;
                sched_addr_q <= {round_q, 2'b00};
            end else if (keydone && (state == ISSUE) && (cnt_q != 2'd3)) begin
                cnt_q        <= cnt_q + 2'd1;
                sched_addr_q <= sched_addr_q + 6'd1;
            end
            // Published only on a completed fetch, so aborts leave it intact
            if (keydone && (state == DONE))
                rk_data_q <= {key_buf_q[0], key_buf_q[1], key_buf_q[2], key_buf_q[3]};
        end
    end

    always_ff @(posedge clk) begin
        rd_slot_p1 <= issue_slot_p0;
        rd_slot_p2 <= rd_slot_p1;
        if (cap_vld) key_buf_q[cap_slot] <= mem_rdata;
    end

    assign mem_address = keydone ? sched_addr_q : ksa_address;
    assign mem_r_wbar  = keydone ? 1'b1 : ksa_mem_r_wbar;

    assign rk.rk_ready = rk_ready_int;
    assign rk.rk_valid = rk_valid_q;
    assign rk.rk_data  = rk_data_q;
    assign rk.rk_err   = keydone & (state == CHECK) & round_bad;
endmodule

// File: tb/tb_aes_round_key_scheduler.sv
// Directed bench for aes_round_key_scheduler with MEM_LAT=1.
// Key memory model: mem[i] = 32'hC0DE_0000 + i, registered read.
module tb_aes_round_key_scheduler;
`ifdef RK_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [1:0]  length;
    logic        keydone;
    logic [5:0]  ksa_address;
    logic        ksa_mem_r_wbar;
    logic [5:0]  mem_address;
    logic        mem_r_wbar;
    logic [31:0] mem_rdata;

    int pass_cnt;
    int total_cnt;

    aes_round_key_scheduler_if rk_if();

    aes_round_key_scheduler #(.MEM_LAT(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .length         (length),
        .keydone        (keydone),
        .ksa_address    (ksa_address),
        .ksa_mem_r_wbar (ksa_mem_r_wbar),
        .mem_address    (mem_address),
        .mem_r_wbar     (mem_r_wbar),
        .mem_rdata      (mem_rdata),
        .rk             (rk_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= 32'hC0DE0000 + {26'd0, mem_address};

    function automatic logic [127:0] key(input int r);
        key = {32'hC0DE0000 + 32'(4*r),     32'hC0DE0000 + 32'(4*r + 1),
               32'hC0DE0000 + 32'(4*r + 2), 32'hC0DE0000 + 32'(4*r + 3)};
    endfunction

    // Request round r (caller is #1 after an edge with rk_ready=1), then watch
    // up to budget cycles; n counts edges after the accepting edge.
    task automatic fetch(input logic [3:0] r, input int budget, output int lat,
                         output logic [127:0] data, output int errs, output int bad_addr,
                         output int bad_rw, output int moves, output logic rdy_at_vld);
        logic [5:0] prev_a;
        logic [5:0] exp_a;
        lat = -1; data = '0; errs = 0; bad_addr = 0; bad_rw = 0; moves = 0; rdy_at_vld = 1'b0;
        prev_a = mem_address;
        rk_if.rk_req = 1'b1;
        rk_if.rk_round = r;
        @(posedge clk); #1;
        rk_if.rk_req = 1'b0;
        for (int n = 0; n < budget; n++) begin
            exp_a = {r, 2'b00} + 6'(n - 1);
            if (n >= 1 && n <= 4 && mem_address !== exp_a) bad_addr++;
            if (mem_r_wbar !== 1'b1) bad_rw++;
            if (mem_address !== prev_a) moves++;
            prev_a = mem_address;
            if (rk_if.rk_err === 1'b1) errs++;
            if (rk_if.rk_valid === 1'b1) begin
                lat = n;
                data = rk_if.rk_data;
                rdy_at_vld = rk_if.rk_ready;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; keydone = 1'b1; length = 2'b00;
        ksa_address = 6'h15; ksa_mem_r_wbar = 1'b0;
        rk_if.rk_req = 1'b0; rk_if.rk_round = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (rk_if.rk_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", rk_if.rk_ready); else pass_cnt++;
        total_cnt++; if (rk_if.rk_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rk_if.rk_valid); else pass_cnt++;
        total_cnt++; if (rk_if.rk_err !== 1'b0) $display("FAIL reset_err: got %b want 0", rk_if.rk_err); else pass_cnt++;
        total_cnt++; if (rk_if.rk_data !== 128'd0) $display("FAIL reset_data: got %h want 0", rk_if.rk_data); else pass_cnt++;
        total_cnt++; if (mem_address !== 6'd0) $display("FAIL reset_addr: got %0d want 0", mem_address); else pass_cnt++;
        total_cnt++; if (mem_r_wbar !== 1'b1) $display("FAIL reset_rw: got %b want 1", mem_r_wbar); else pass_cnt++;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fetch_basic();
        int lat, errs, ba, brw, mv; logic [127:0] d; logic rdy;
        length = 2'b00;
        fetch(4'd3, 12, lat, d, errs, ba, brw, mv, rdy);
        total_cnt++; if (lat !== 7) $display("FAIL basic_latency: got %0d want 7", lat); else pass_cnt++;
        total_cnt++; if (d !== key(3)) $display("FAIL basic_data: got %h want %h", d, key(3)); else pass_cnt++;
        total_cnt++; if (ba !== 0) $display("FAIL basic_addr_order: got %0d bad want 0", ba); else pass_cnt++;
        total_cnt++; if (brw !== 0) $display("FAIL basic_r_wbar: got %0d bad want 0", brw); else pass_cnt++;
        total_cnt++; if (errs !== 0) $display("FAIL basic_err: got %0d want 0", errs); else pass_cnt++;
        total_cnt++; if (mv !== 4) $display("FAIL basic_addr_moves: got %0d want 4", mv); else pass_cnt++;
    endtask

    task automatic test_range();
        int lat, errs, ba, brw, mv; logic [127:0] d; logic rdy; logic [5:0] a0;
        length = 2'b00;
        a0 = mem_address;
        fetch(4'd11, 10, lat, d, errs, ba, brw, mv, rdy);
        total_cnt++; if (errs !== 1) $display("FAIL err11_pulse: got %0d want 1", errs); else pass_cnt++;
        total_cnt++; if (lat !== -1) $display("FAIL err11_novalid: got %0d want -1", lat); else pass_cnt++;
        total_cnt++; if (mem_address !== a0) $display("FAIL err11_addr: got %0d want %0d", mem_address, a0); else pass_cnt++;
        fetch(4'd10, 12, lat, d, errs, ba, brw, mv, rdy);
        total_cnt++; if (lat !== 7 || errs !== 0) $display("FAIL r10_latency: got %0d/%0d want 7/0", lat, errs); else pass_cnt++;
        total_cnt++; if (d !== key(10)) $display("FAIL r10_data: got %h want %h", d, key(10)); else pass_cnt++;
        length = 2'b11;
        fetch(4'd14, 12, lat, d, errs, ba, brw, mv, rdy);
        total_cnt++; if (lat !== 7) $display("FAIL r14_latency: got %0d want 7", lat); else pass_cnt++;
        total_cnt++; if (d !== key(14)) $display("FAIL r14_data: got %h want %h", d, key(14)); else pass_cnt++;
        total_cnt++; if (ba !== 0) $display("FAIL r14_addr_order: got %0d bad want 0", ba); else pass_cnt++;
        length = 2'b10;
        fetch(4'd13, 10, lat, d, errs, ba, brw, mv, rdy);
        total_cnt++; if (errs !== 1 || lat !== -1) $display("FAIL err13_192: got err %0d lat %0d want 1/-1", errs, lat); else pass_cnt++;
        fetch(4'd12, 12, lat, d, errs, ba, brw, mv, rdy);
        total_cnt++; if (d !== key(12) || errs !== 0) $display("FAIL r12_192_data: got %h want %h", d, key(12)); else pass_cnt++;
        length = 2'b00;
    endtask

    task automatic test_back_to_back();
        int lat, errs, ba, brw, mv; logic [127:0] d; logic rdy;
        length = 2'b00;
        fetch(4'd1, 12, lat, d, errs, ba, brw, mv, rdy);
        total_cnt++; if (d !== key(1)) $display("FAIL b2b_first_data: got %h want %h", d, key(1)); else pass_cnt++;
        total_cnt++; if (rdy !== 1'b1) $display("FAIL b2b_ready_at_valid: got %b want 1", rdy); else pass_cnt++;
        fetch(4'd2, 12, lat, d, errs, ba, brw, mv, rdy);
        total_cnt++; if (lat !== 7) $display("FAIL b2b_second_latency: got %0d want 7", lat); else pass_cnt++;
        total_cnt++; if (d !== key(2)) $display("FAIL b2b_second_data: got %h want %h", d, key(2)); else pass_cnt++;
    endtask

    task automatic test_ksa_owner();
        int seen;
        logic [7:0] got, want;
        keydone = 1'b0;
        rk_if.rk_req = 1'b1;
        rk_if.rk_round = 4'd4;
        for (int i = 0; i < 6; i++) begin
            ksa_address = 6'(i);
            ksa_mem_r_wbar = 1'(i % 2);
            #1;
            got  = {mem_address, mem_r_wbar, rk_if.rk_ready};
            want = {6'(i), 1'(i % 2), 1'b0};
            total_cnt++; if (got !== want) $display("FAIL ksa_mirror_%0d: got %h want %h", i, got, want); else pass_cnt++;
            @(posedge clk); #1;
        end
        rk_if.rk_req = 1'b0;
        keydone = 1'b1;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (rk_if.rk_valid !== 1'b0 || rk_if.rk_err !== 1'b0) seen++;
        end
        total_cnt++; if (seen !== 0) $display("FAIL ksa_req_ignored: got %0d events want 0", seen); else pass_cnt++;
        total_cnt++; if (rk_if.rk_ready !== 1'b1) $display("FAIL ksa_ready_after: got %b want 1", rk_if.rk_ready); else pass_cnt++;
    endtask

    task automatic test_abort();
        int lat, errs, ba, brw, mv, seen; logic [127:0] d; logic rdy;
        length = 2'b00;
        fetch(4'd2, 12, lat, d, errs, ba, brw, mv, rdy);
        rk_if.rk_req = 1'b1;
        rk_if.rk_round = 4'd5;
        @(posedge clk); #1;
        rk_if.rk_req = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        ksa_address = 6'h2A;
        ksa_mem_r_wbar = 1'b0;
        keydone = 1'b0;
        #1;
        total_cnt++; if (mem_address !== 6'h2A) $display("FAIL abort_addr_to_ksa: got %h want 2a", mem_address); else pass_cnt++;
        total_cnt++; if (mem_r_wbar !== 1'b0) $display("FAIL abort_rw_to_ksa: got %b want 0", mem_r_wbar); else pass_cnt++;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (rk_if.rk_valid !== 1'b0) seen++;
        end
        total_cnt++; if (seen !== 0) $display("FAIL abort_no_valid: got %0d want 0", seen); else pass_cnt++;
        total_cnt++; if (rk_if.rk_data !== key(2)) $display("FAIL abort_data_kept: got %h want %h", rk_if.rk_data, key(2)); else pass_cnt++;
        keydone = 1'b1;
        #1;
        total_cnt++; if (rk_if.rk_ready !== 1'b1) $display("FAIL abort_idle: got %b want 1", rk_if.rk_ready); else pass_cnt++;
        fetch(4'd5, 12, lat, d, errs, ba, brw, mv, rdy);
        total_cnt++; if (lat !== 7) $display("FAIL abort_refetch_latency: got %0d want 7", lat); else pass_cnt++;
        total_cnt++; if (d !== key(5)) $display("FAIL abort_refetch_data: got %h want %h", d, key(5)); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        int lat, errs, ba, brw, mv; logic [127:0] d; logic rdy;
        rk_if.rk_req = 1'b1;
        rk_if.rk_round = 4'd6;
        @(posedge clk); #1;
        rk_if.rk_req = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b0;
        #1;
        total_cnt++; if (rk_if.rk_ready !== 1'b0) $display("FAIL areset_ready: got %b want 0", rk_if.rk_ready); else pass_cnt++;
        total_cnt++; if (rk_if.rk_data !== 128'd0) $display("FAIL areset_data: got %h want 0", rk_if.rk_data); else pass_cnt++;
        total_cnt++; if (mem_address !== 6'd0) $display("FAIL areset_addr: got %0d want 0", mem_address); else pass_cnt++;
        total_cnt++; if ({rk_if.rk_valid, rk_if.rk_err} !== 2'b00) $display("FAIL areset_pulses: got %b want 00", {rk_if.rk_valid, rk_if.rk_err}); else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        fetch(4'd7, 12, lat, d, errs, ba, brw, mv, rdy);
        total_cnt++; if (lat !== 7) $display("FAIL areset_after_latency: got %0d want 7", lat); else pass_cnt++;
        total_cnt++; if (d !== key(7)) $display("FAIL areset_after_data: got %h want %h", d, key(7)); else pass_cnt++;
    endtask

    task automatic test_cache();
        int lat, errs, ba, brw, mv; logic [127:0] d; logic rdy;
        length = 2'b00;
        fetch(4'd3, 12, lat, d, errs, ba, brw, mv, rdy);
        total_cnt++; if (lat !== 7 || d !== key(3)) $display("FAIL cache_first: got lat %0d data %h want 7 %h", lat, d, key(3)); else pass_cnt++;
        fetch(4'd3, 12, lat, d, errs, ba, brw, mv, rdy);
        total_cnt++; if (lat !== (CACHE ? 0 : 7)) $display("FAIL cache_second_latency: got %0d want %0d", lat, CACHE ? 0 : 7); else pass_cnt++;
        total_cnt++; if (d !== key(3)) $display("FAIL cache_second_data: got %h want %h", d, key(3)); else pass_cnt++;
        total_cnt++; if (mv !== (CACHE ? 0 : 4)) $display("FAIL cache_second_reads: got %0d want %0d", mv, CACHE ? 0 : 4); else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        test_reset();
        test_fetch_basic();
        test_range();
        test_back_to_back();
        test_ksa_owner();
        test_abort();
        test_async_reset();
        test_cache();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
